// File: rtl/clock24_time_setter_pkg.sv
// Shared types and constants for the 24-hour clock time-set controller.
// Holds field widths, range limits, the edit FSM state enum and wrap-step helpers.
package clock24_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;

    localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
    localparam logic [MINUTES_W-1:0] MAX_MINUTES = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;

    function automatic logic [HOURS_W-1:0] hours_step(input logic [HOURS_W-1:0] h,
                                                      input logic up);
        if (up) return (h == MAX_HOURS) ? '0 : h + 1'b1;
        return (h == '0) ? MAX_HOURS : h - 1'b1;
    endfunction

    function automatic logic [MINUTES_W-1:0] minutes_step(input logic [MINUTES_W-1:0] m,
                                                          input logic up);
        if (up) return (m == MAX_MINUTES) ? '0 : m + 1'b1;
        return (m == '0) ? MAX_MINUTES : m - 1'b1;
    endfunction

endpackage

// File: rtl/clock24_time_setter_if.sv
// Front-panel / clock-counter load interface of the time setter.
// master = the setter (drives set_*, propagate, blink info); slave = the panel and counter side.
interface clock24_time_setter_if;
    import clock24_pkg::*;

    logic                 btn_mode;
    logic                 btn_up;
    logic                 btn_down;
    logic [HOURS_W-1:0]   cur_hours;
    logic [MINUTES_W-1:0] cur_minutes;
    logic [HOURS_W-1:0]   set_hours;
    logic [MINUTES_W-1:0] set_minutes;
    logic                 propagate;
    logic                 editing;
    logic [1:0]           edit_field;

    modport master (
        input  btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
        output set_hours, set_minutes, propagate, editing, edit_field
    );

    modport slave (
        output btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
        input  set_hours, set_minutes, propagate, editing, edit_field
    );

endinterface

// File: rtl/clock24_time_setter_btn_press_detect.sv
// Rising-edge press detector for one debounced button level, with optional hold/auto-repeat
// stepping when CLOCK24_TIME_SETTER_AUTOREPEAT_EN is defined.
module btn_press_detect #(
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic repeat_step
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= btn;
    end

    assign press = btn & ~prev;

`ifdef CLOCK24_TIME_SETTER_AUTOREPEAT_EN
    localparam int HOLD_N   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
    localparam int REPEAT_N = (REPEAT_CYCLES < 1) ? 1 : REPEAT_CYCLES;
    localparam int RPT_MAX  = (HOLD_N > REPEAT_N) ? HOLD_N : REPEAT_N;
    localparam int RW       = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt;

    // Down-counter reaches zero exactly on each repeat edge while the button stays held.
    always_ff @(posedge clk) begin
        if (reset || !btn)       rpt_cnt <= '0;
        else if (press)          rpt_cnt <= RW'(HOLD_N - 1);
        else if (rpt_cnt == '0)  rpt_cnt <= RW'(REPEAT_N - 1);
        else                     rpt_cnt <= rpt_cnt - 1'b1;
    end

    assign repeat_step = btn & prev & (rpt_cnt == '0);
`else
    assign repeat_step = 1'b0;

    // Hold/repeat timing is inert without auto-repeat; the block only keeps the knobs referenced.
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_repeat_cfg_inert
    end
`endif

endmodule

// File: rtl/clock24_time_setter.sv
// Front-panel time-set controller driving the 24-hour clock counter's load port.
// Optional auto-repeat on held up/down buttons: define CLOCK24_TIME_SETTER_AUTOREPEAT_EN.
//
//   state  | meaning
//   IDLE   | not editing; set_* hold last value; mode press captures live time
//   EDIT_H | hours field selected; up/down wrap 0..23
//   EDIT_M | minutes field selected; up/down wrap 0..59
//   COMMIT | one-cycle propagate pulse loading set_* into the counter
module clock24_time_setter import clock24_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int HOLD_CYCLES    = 8,
    parameter int REPEAT_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    clock24_time_setter_if.master tsif
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state, state_n;
    logic [HOURS_W-1:0]   hours_q, hours_n;
    logic [MINUTES_W-1:0] minutes_q, minutes_n;
    logic [TO_W-1:0]      to_cnt, to_cnt_n;
    logic                 accept;
    logic                 timeout_hit;

    logic mode_press, mode_rpt;
    logic up_press, up_rpt;
    logic down_press, down_rpt;
    logic up_step, down_step, up_go, down_go;

    btn_press_detect #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .btn(tsif.btn_mode), .press(mode_press), .repeat_step(mode_rpt)
    );

    btn_press_detect #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .clk(clk), .reset(reset), .btn(tsif.btn_up), .press(up_press), .repeat_step(up_rpt)
    );

    btn_press_detect #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
        .clk(clk), .reset(reset), .btn(tsif.btn_down), .press(down_press), .repeat_step(down_rpt)
    );

    // Holding the opposite button suppresses repeat; simultaneous steps cancel out.
    assign up_step   = up_press   | (up_rpt   & ~tsif.btn_down);
    assign down_step = down_press | (down_rpt & ~tsif.btn_up);
    assign up_go     = up_step   & ~down_step;
    assign down_go   = down_step & ~up_step;

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST);

    always_comb begin
        state_n   = state;
        hours_n   = hours_q;
        minutes_n = minutes_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (mode_press) begin
                    hours_n   = (tsif.cur_hours   > MAX_HOURS)   ? '0 : tsif.cur_hours;
                    minutes_n = (tsif.cur_minutes > MAX_MINUTES) ? '0 : tsif.cur_minutes;
                    state_n   = EDIT_H;
                end
            end
            EDIT_H: begin
                if (mode_press) begin
                    state_n = EDIT_M;
                    accept  = 1'b1;
                end else if (up_go || down_go) begin
                    hours_n = hours_step(hours_q, up_go);
                    accept  = 1'b1;
                end else if (timeout_hit) begin
                    state_n = IDLE;
                end
            end
            EDIT_M: begin
                if (mode_press) begin
                    state_n = COMMIT;
                    accept  = 1'b1;
                end else if (up_go || down_go) begin
                    minutes_n = minutes_step(minutes_q, up_go);
                    accept    = 1'b1;
                end else if (timeout_hit) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        to_cnt_n = to_cnt + 1'b1;
        if (TIMEOUT_CYCLES == 0 || accept || state_n != state ||
            !(state_n inside {EDIT_H, EDIT_M}))
            to_cnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hours_q   <= '0;
            minutes_q <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_n;
            hours_q   <= hours_n;
            minutes_q <= minutes_n;
            to_cnt    <= to_cnt_n;
        end
    end

    assign tsif.set_hours   = hours_q;
    assign tsif.set_minutes = minutes_q;
    assign tsif.propagate   = (state == COMMIT);
    assign tsif.editing     = (state == EDIT_H) || (state == EDIT_M);
    assign tsif.edit_field  = (state == EDIT_H) ? FIELD_HOURS :
                              (state == EDIT_M) ? FIELD_MINUTES : FIELD_NONE;

endmodule
